// File: rtl/cla_pkg.sv
// Shared definitions for the multi-precision CLA sequencer: byte width, FSM states and the
// counter-width helper.
package cla_pkg;

   localparam int unsigned BYTE_W = 8;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   // Byte counter width; never narrower than one bit.
   function automatic int unsigned cnt_w(input int unsigned words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

endpackage

// File: rtl/cla_dataflow.sv
// 8-bit carry-lookahead adder, purely combinational: two 4-bit lookahead groups, with the
// lower group's carry-out feeding the upper group.
module cla_dataflow (
   output logic [7:0] sum,
   output logic       cout,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin
);

   logic [7:0] g;
   logic [7:0] p;
   logic [8:0] c;
   logic [4:0] c_lo;
   logic [4:0] c_hi;

   // Carries c[4:0] of one 4-bit group, with each carry a flat sum of products.
   function automatic logic [4:0] cla4(input logic [3:0] gi, input logic [3:0] pi,
                                       input logic ci);
      logic [4:0] co;
      co[0] = ci;
      co[1] = gi[0] | (pi[0] & ci);
      co[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & ci);
      co[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0]) |
              (pi[2] & pi[1] & pi[0] & ci);
      co[4] = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1]) |
              (pi[3] & pi[2] & pi[1] & gi[0]) | (&pi & ci);
      return co;
   endfunction

   always_comb begin
      g    = a & b;
      p    = a ^ b;
      c_lo = cla4(g[3:0], p[3:0], cin);
      c_hi = cla4(g[7:4], p[7:4], c_lo[4]);
      c    = {c_hi, c_lo[3:0]};
      sum  = p ^ c[7:0];
      cout = c[8];
   end

endmodule

// File: rtl/cla_mp_sequencer.sv
// Multi-precision add/subtract sequencer: streams WORDS-byte operands through one shared 8-bit
// CLA, LSB byte first, with a registered carry linking the bytes.
module cla_mp_sequencer
   import cla_pkg::*;
#(
   parameter int unsigned WORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [BYTE_W*WORDS-1:0] op_a,
   input  logic [BYTE_W*WORDS-1:0] op_b,
   input  logic                  sub,
   input  logic                  cin,
   output logic                  busy,
   output logic                  done,
   output logic [BYTE_W*WORDS-1:0] result,
   output logic                  cout,
   output logic                  overflow
);

   localparam int unsigned W    = BYTE_W * WORDS;
   localparam int unsigned CntW = cnt_w(WORDS);

   state_e              state_q;
   logic [CntW-1:0]     cnt_q;
   logic                carry_q;
   logic [W-1:0]        a_q;
   logic [W-1:0]        b_q;
   logic [W-1:0]        result_q;
   logic                cout_q;
   logic                ovf_q;
   logic                done_q;
   logic                busy_q;

   logic [BYTE_W-1:0]   sum;
   logic                add_cout;
   logic                last_byte;
   logic                carry_into_msb;

   cla_dataflow u_add (
      .sum  (sum),
      .cout (add_cout),
      .a    (a_q[BYTE_W-1:0]),
      .b    (b_q[BYTE_W-1:0]),
      .cin  (carry_q)
   );

   assign last_byte      = (cnt_q == CntW'(WORDS - 1));
   // b_q already holds the inverted operand in subtract mode.
   assign carry_into_msb = a_q[BYTE_W-1] ^ b_q[BYTE_W-1] ^ sum[BYTE_W-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               done_q <= 1'b0;
               if (start) begin
                  a_q     <= op_a;
                  b_q     <= sub ? ~op_b : op_b;
                  carry_q <= cin ^ sub;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= StRun;
               end
            end
            StRun: begin
               a_q      <= a_q >> BYTE_W;
               b_q      <= b_q >> BYTE_W;
               result_q <= {sum, result_q[W-1:BYTE_W]};
               carry_q  <= add_cout;
               cnt_q    <= cnt_q + 1'b1;
               if (last_byte) begin
                  cout_q  <= add_cout;
                  ovf_q   <= carry_into_msb ^ add_cout;
                  done_q  <= 1'b1;
                  state_q <= StDone;
               end
            end
            StDone: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign result   = result_q;
   assign cout     = cout_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_cla_mp_sequencer.sv
// Directed and random self-checking bench for cla_mp_sequencer with WORDS=4.
module tb_cla_mp_sequencer;

   localparam int unsigned WORDS = 4;
   localparam int unsigned W     = 8 * WORDS;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         sub;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cout;
   logic         overflow;

   int checks;
   int errors;

   cla_mp_sequencer #(
      .WORDS (WORDS)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .op_a     (op_a),
      .op_b     (op_b),
      .sub      (sub),
      .cin      (cin),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .cout     (cout),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one operation and wait (bounded) for done; checks latency, busy span and the
   // return to idle, and hands back the values seen while done was high.
   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic c, output logic [W-1:0] r,
                         output logic co, output logic ov);
      int n;
      int busy_cnt;
      int done_cycle;
      bit got;
      @(negedge clk);
      op_a  = a;
      op_b  = b;
      sub   = s;
      cin   = c;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      // Operands are free to change once accepted.
      op_a  = $urandom;
      op_b  = $urandom;
      sub   = ~s;
      cin   = ~c;
      n = 1;
      busy_cnt = 0;
      done_cycle = 0;
      got = 1'b0;
      r  = '0;
      co = 1'b0;
      ov = 1'b0;
      while (n <= 20 && !got) begin
         if (busy) busy_cnt++;
         if (done) begin
            got = 1'b1;
            done_cycle = n;
            r  = result;
            co = cout;
            ov = overflow;
         end else begin
            @(posedge clk);
            #1;
            n++;
         end
      end
      check({tag, "_done_seen"}, 64'(got), 64'd1);
      check({tag, "_latency"}, 64'(done_cycle), 64'(WORDS + 1));
      @(posedge clk);
      #1;
      if (busy) busy_cnt++;
      check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(WORDS + 1));
      check({tag, "_done_pulse"}, 64'(done), 64'd0);
   endtask

   logic [W-1:0] r;
   logic         co;
   logic         ov;
   logic [W-1:0] ra;
   logic [W-1:0] rb;
   logic [W-1:0] bb;
   logic [W-1:0] exp_r;
   logic         exp_co;
   logic         exp_ov;
   logic         rs;
   logic         rc;
   int           dcount;
   logic [W-1:0] seen_r;

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      start  = 1'b0;
      op_a   = '0;
      op_b   = '0;
      sub    = 1'b0;
      cin    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_result", 64'(result), 64'd0);
      check("reset_cout", 64'(cout), 64'd0);
      check("reset_ovf", 64'(overflow), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Add with full carry propagation out of the top byte.
      run_op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, r, co, ov);
      check("add_wrap_result", 64'(r), 64'h0000_0000);
      check("add_wrap_cout", 64'(co), 64'd1);
      check("add_wrap_ovf", 64'(ov), 64'd0);

      run_op("sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, r, co, ov);
      check("sub_borrow_result", 64'(r), 64'hFFFF_FFFE);
      check("sub_borrow_cout", 64'(co), 64'd0);
      check("sub_borrow_ovf", 64'(ov), 64'd0);

      run_op("sub_pos", 32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0, r, co, ov);
      check("sub_pos_result", 64'(r), 64'h0000_0002);
      check("sub_pos_cout", 64'(co), 64'd1);

      run_op("sub_bin", 32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, r, co, ov);
      check("sub_bin_result", 64'(r), 64'h0000_0001);
      check("sub_bin_cout", 64'(co), 64'd1);

      run_op("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, r, co, ov);
      check("add_ovf_result", 64'(r), 64'h8000_0000);
      check("add_ovf_cout", 64'(co), 64'd0);
      check("add_ovf_ovf", 64'(ov), 64'd1);

      run_op("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, r, co, ov);
      check("sub_ovf_result", 64'(r), 64'h7FFF_FFFF);
      check("sub_ovf_cout", 64'(co), 64'd1);
      check("sub_ovf_ovf", 64'(ov), 64'd1);

      run_op("chain", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b1, r, co, ov);
      check("chain_result", 64'(r), 64'h0000_0101);
      check("chain_cout", 64'(co), 64'd0);
      check("chain_ovf", 64'(ov), 64'd0);

      // Start pulses while busy (RUN cycle 2 and the DONE cycle) must be dropped.
      @(negedge clk);
      op_a  = 32'h0000_0012;
      op_b  = 32'h0000_0034;
      sub   = 1'b0;
      cin   = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      dcount = 0;
      seen_r = '0;
      for (int n = 1; n <= 12; n++) begin
         if (n == 2 || n == 5) begin
            start = 1'b1;
            op_a  = 32'hDEAD_BEEF;
            op_b  = 32'h0BAD_F00D;
            sub   = 1'b1;
            cin   = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            dcount++;
            seen_r = result;
         end
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      check("busy_start_done_count", 64'(dcount), 64'd1);
      check("busy_start_result", 64'(seen_r), 64'h0000_0046);
      check("busy_start_idle", 64'(busy), 64'd0);
      check("busy_start_held", 64'(result), 64'h0000_0046);

      // Asynchronous reset in RUN cycle 2 discards the operation.
      @(negedge clk);
      op_a  = 32'hFFFF_FFFF;
      op_b  = 32'hFFFF_FFFF;
      sub   = 1'b0;
      cin   = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_result", 64'(result), 64'd0);
      check("rst_cout", 64'(cout), 64'd0);
      check("rst_ovf", 64'(overflow), 64'd0);
      dcount = 0;
      repeat (2) begin
         @(posedge clk);
         #1;
         if (done) dcount++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (WORDS + 2) begin
         @(posedge clk);
         #1;
         if (done) dcount++;
      end
      check("rst_no_done", 64'(dcount), 64'd0);

      run_op("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, r, co, ov);
      check("post_rst_result", 64'(r), 64'h2345_6789);
      check("post_rst_cout", 64'(co), 64'd0);
      check("post_rst_ovf", 64'(ov), 64'd0);

      // Random regression against a W-bit reference.
      for (int i = 0; i < 1000; i++) begin
         ra = $urandom;
         rb = $urandom;
         rs = 1'($urandom_range(0, 1));
         rc = 1'($urandom_range(0, 1));
         bb = rs ? ~rb : rb;
         {exp_co, exp_r} = {1'b0, ra} + {1'b0, bb} + 33'(rc ^ rs);
         exp_ov = (ra[W-1] == bb[W-1]) && (exp_r[W-1] != ra[W-1]);
         run_op("rnd", ra, rb, rs, rc, r, co, ov);
         check("rnd_result", 64'(r), 64'(exp_r));
         check("rnd_cout", 64'(co), 64'(exp_co));
         check("rnd_ovf", 64'(ov), 64'(exp_ov));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cla_mp_sequencer.md
Name: cla_mp_sequencer

Overview:
Multi-precision add/subtract sequencer built around one 8-bit carry-lookahead adder. It accepts WORDS-byte operands and runs them through the 8-bit adder one byte per cycle, LSB byte first. A registered carry links the bytes. Requesters use it as a wide adder without paying for a full-width CLA; it sits between the control FSMs and the shared 8-bit adder datapath.

Parameters:
WORDS, 4, number of 8-bit bytes per operand (legal range 2..16); operand width W = 8*WORDS.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  request pulse; sampled only in IDLE.
op_a  input  W  operand A; captured on accepted start.
op_b  input  W  operand B; captured on accepted start.
sub  input  1  0 = A+B+cin, 1 = A-B-cin (borrow-in); captured on accepted start.
cin  input  1  carry-in (add) or borrow-in (sub); captured on accepted start.
busy  output  1  high whenever state != IDLE.
done  output  1  one-cycle pulse; result, cout and overflow are valid.
result  output  W  sum/difference; held until the next accepted start.
cout  output  1  final carry-out; in sub mode, 1 = no borrow.
overflow  output  1  two's-complement signed overflow of the W-bit operation.

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset is asynchronous, active-low on rst_n. While rst_n=0: state=IDLE; byte counter=0; carry reg=0; operand regs=0; busy=0, done=0, result=0, cout=0, overflow=0.
  - Reset mid-operation discards all partial results. No done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0: capture op_a, op_b, and sub. If sub=1, capture ~op_b instead of op_b.
  - Carry reg <= cin ^ sub.
  - Counter <= 0; state -> RUN.
  - start=0: stay in IDLE.
- RUN, edges E1..E_WORDS, byte i = counter:
  - Adder inputs: a = A_reg[7:0], b = B_reg[7:0], cin = carry reg.
  - A_reg and B_reg shift right by 8.
  - The result shift register shifts right by 8 and inserts the sum byte at bits [W-1:W-8].
  - Carry reg <= adder cout; counter increments.
  - On the last byte (counter = WORDS-1):
    - cout <= adder cout.
    - overflow <= (carry into bit 7 of the top byte) XOR (adder cout), where carry into bit 7 = a[7] ^ b[7] ^ sum[7] of that byte (b is the post-inversion value).
    - state -> DONE.
  - The result register updates in place during RUN. Consumers sample only on done.
- DONE:
  - done=1 for exactly this cycle.
  - Next edge -> IDLE unconditionally. start during DONE is ignored.
- Latency: start sampled at E0 -> done high in the cycle after edge E_WORDS, i.e. WORDS+1 cycles after start is sampled.
- Throughput: one operation per WORDS+2 cycles.
- start while busy=1: ignored, with no effect on the operation in flight.
- op_a, op_b, sub and cin may change freely after the accepting edge.
- Width rules:
  - Counter width = $clog2(WORDS).
  - All arithmetic is modulo 2^W; the carry beyond W goes to cout only.
- sub=1, cin=1 yields A-B-1, which supports borrow chaining across multiple sequencer operations.

Decomposition:
- Shared package cla_pkg holds:
  - BYTE_W=8.
  - State enum typedef for IDLE/RUN/DONE.
  - Localparam helper for counter width.
- One sub-module: the team's existing 8-bit CLA adder cla_dataflow (ports sum, cout, a, b, cin), instantiated once, purely combinational.
- The sequencer contains all registers, the FSM, and the operand and result shifters.

Test Plan:
- WORDS=4, add, A=0xFFFFFFFF, B=0x00000001, cin=0 -> result=0x00000000, cout=1, overflow=0; done exactly 5 cycles after the start edge; busy high for 5 cycles.
- Sub, A=0x00000005, B=0x00000007, cin=0 -> result=0xFFFFFFFE, cout=0 (borrow), overflow=0; separately A=7, B=5 -> result=0x00000002, cout=1.
- Add A=0x7FFFFFFF, B=0x00000001 -> result=0x80000000, overflow=1, cout=0; sub A=0x80000000, B=1 -> result=0x7FFFFFFF, overflow=1.
- Start in IDLE, then pulse start with different operands on cycles 2 and 5 (busy) -> first operation's result unchanged, exactly one done pulse, second request dropped.
- Drop rst_n in RUN cycle 2 -> all outputs 0 immediately (asynchronous); no done; after release, a fresh operation A=0x12345678 + B=0x11111111 -> 0x23456789.
- Chained: add A=0x000000FF, B=0x00000001, cin=1 -> 0x00000101; random regression of 1000 operands (both modes, both cin values) checked against a W-bit reference model.
